if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Parametrised instruction-fetch front end. It replaces the single-entry fetch stage with a pipelined requester that keeps up to OUTSTANDING instruction requests in flight on the SRAM-like bus. Returned instructions are buffered in a FIFO_DEPTH-entry queue feeding ID. On a redirect it flushes the queue and silently drops responses for requests already issued. It sits between the CSR/MEM/ID redirect sources and the ID stage.

## Interface
Parameters:
- PC_RESET, 32'h1c00_0000, first fetch address after reset
- OUTSTANDING, 2, max accepted-but-unanswered requests (1..8)
- FIFO_DEPTH, 4, instruction queue entries (power of 2, ≥ OUTSTANDING)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high (one clock; reset is synchronous and active-high)
- redirect_valid  in  1  exception, ertn or taken branch; the source resolves priority upstream
- redirect_pc  in  32  new fetch address
- fetch_stall  in  1  suppress new requests (branch not yet resolvable)
- out_valid  out  1  queue head valid
- out_ready  in  1  ID accepts head (id_allowin)
- out_pc  out  32  head PC
- out_inst  out  32  head instruction; 0 when out_adef
- out_adef  out  1  head carries ADEF exception
- inst_sram_req  out  1; inst_sram_wr  out  1 (const 0); inst_sram_wstrb  out  4 (const 0); inst_sram_size  out  2 (const 2'b10); inst_sram_addr  out  32; inst_sram_wdata  out  32 (const 0)
- inst_sram_rdata  in  32; inst_sram_addr_ok  in  1; inst_sram_data_ok  in  1

## Operation
- State: fetch_pc, inflight (0..OUTSTANDING), discard (0..OUTSTANDING, discard ≤ inflight), PC tag queue (OUTSTANDING deep), instruction FIFO of {pc, inst, adef}, and the adef_hold flag.
- Issue condition: ~reset & ~redirect_valid & ~fetch_stall & ~adef_hold & fetch_pc[1:0]==0 & inflight<OUTSTANDING & (inflight−discard+fifo_count)<FIFO_DEPTH. inst_sram_req = issue condition; inst_sram_addr = fetch_pc.
- Accept (req & addr_ok): fetch_pc += 4, push fetch_pc into the tag queue, inflight++.
- data_ok: pop the tag queue, inflight--. If discard>0, discard-- and drop the data. Otherwise push {tag, rdata, 0} into the FIFO.
- Accept and data_ok in the same cycle: inflight is unchanged, and the tag queue pushes and pops together.
- The credit check guarantees the FIFO never overflows. A push into a full FIFO is a design error; the bench must assert on it.
- Misaligned fetch_pc: issue no request. Once inflight==discard and the FIFO is not full, push {fetch_pc, 32'h0, 1} and set adef_hold. Fetch stays stopped until a redirect.
- Redirect (highest priority):
  - fetch_pc ← redirect_pc; FIFO emptied; adef_hold ← 0.
  - discard ← inflight − data_ok (every still-pending response becomes junk).
  - No accept occurs in this cycle because req is forced low.
  - out_ready in the same cycle is ignored.
- Pop: out_valid & out_ready removes the head.

## Timing
- Reset: fetch_pc=PC_RESET, inflight=discard=0, FIFO empty, adef_hold=0. All outputs are 0 during reset: out_valid, out_pc, out_inst, out_adef, inst_sram_req, inst_sram_addr.
- First req rises in the cycle after reset deasserts, with addr=PC_RESET.
- Request hold: once req=1 with addr_ok=0, req and addr stay stable in later cycles. The only exception is redirect_valid, which drops req in that same cycle. fetch_stall does not drop an already-pending req.
- Latency: data_ok in cycle t → out_valid=1 in cycle t+1 (registered FIFO, no bypass).
- Throughput: one accept and one pop per cycle sustained when bus latency ≤ OUTSTANDING cycles.
- out_pc, out_inst and out_adef hold while out_valid & ~out_ready.
- Redirect in cycle t: out_valid=0 at t+1. The new req is visible at t+1 with addr=redirect_pc (if the issue condition holds). A data_ok at t or later for old requests never reaches the FIFO.
- Reset mid-operation: all state clears immediately. Outstanding bus responses after reset are the bus's responsibility; the bench resets the bus model too.

## Test plan
- Straight line, zero-wait bus (addr_ok=1, data_ok one cycle later), out_ready=1 → out_pc 1c000000, 1c000004, 1c000008… one per cycle after a 3-cycle startup.
- Backpressure: out_ready=0 for 10 cycles, FIFO_DEPTH=4 → req deasserts after 4 accepts. Releasing out_ready delivers exactly 4 entries in order, then fetch resumes at 1c000010.
- Redirect with 2 in flight (data_ok delayed 3 cycles), redirect_pc=1c000100 → both old responses dropped (discard 2→0). The next out_pc is 1c000100.
- Redirect in the same cycle as a data_ok, with inflight=2 → discard=1. The next data_ok is dropped, and the following one is delivered with pc=redirect_pc.
- redirect_pc=1c000102 → no bus request is issued. out_valid with out_adef=1, out_pc=1c000102, out_inst=0. No further entries until the next redirect.
- fetch_stall=1 while req is pending with addr_ok=0 → req and addr stay stable. On addr_ok, no further req is issued until stall drops.

Source files
------------

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: pipelined instruction fetch keeping up to OUTSTANDING bus requests in flight,
// buffering returned instructions in a FIFO_DEPTH queue and discarding stale responses after a redirect.
module if_fetch_queue #(
    parameter logic [31:0] PC_RESET    = 32'h1c00_0000,
    parameter int          OUTSTANDING = 2,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        fetch_stall,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_adef,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [3:0]  inst_sram_wstrb,
    output logic [1:0]  inst_sram_size,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic [31:0] inst_sram_rdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok
);
    localparam int IW = $clog2(OUTSTANDING + 1);
    localparam int TW = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
    localparam int FW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + IW + 1;

    logic [31:0]   r_fetch_pc;
    logic [IW-1:0] r_inflight;
    logic [IW-1:0] r_discard;
    logic [31:0]   r_tag [OUTSTANDING];
    logic [TW-1:0] r_tag_wp;
    logic [TW-1:0] r_tag_rp;
    logic [31:0]   r_fpc [FIFO_DEPTH];
    logic [31:0]   r_finst [FIFO_DEPTH];
    logic          r_fadef [FIFO_DEPTH];
    logic [FW-1:0] r_wp;
    logic [FW-1:0] r_rp;
    logic [CW-1:0] r_cnt;
    logic          r_adef_hold;
    logic          r_pending;

    logic        w_issue;
    logic        w_accept;
    logic        w_drop;
    logic        w_full;
    logic        w_empty;
    logic        w_push_data;
    logic        w_push_adef;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_tag_head;

    assign w_full     = r_cnt == CW'(FIFO_DEPTH);
    assign w_empty    = r_cnt == '0;
    assign w_drop     = r_discard != '0;
    assign w_tag_head = r_tag[r_tag_rp];
    // Live requests plus queued entries never exceed the queue size, so every response has a slot.
    // A request left hanging without addr_ok stays up regardless of stall.
    assign w_issue = ~reset & ~redirect_valid & (r_pending | (~fetch_stall & ~r_adef_hold &
                     (r_fetch_pc[1:0] == 2'b00) & (r_inflight < IW'(OUTSTANDING)) &
                     (SW'(r_inflight) - SW'(r_discard) + SW'(r_cnt) < SW'(FIFO_DEPTH))));
    assign w_accept    = w_issue & inst_sram_addr_ok;
    assign w_push_data = ~reset & ~redirect_valid & inst_sram_data_ok & ~w_drop;
    assign w_push_adef = ~reset & ~redirect_valid & ~r_adef_hold & (r_fetch_pc[1:0] != 2'b00) &
                         (r_inflight == r_discard) & ~w_full;
    assign w_push      = w_push_data | w_push_adef;
    assign w_pop       = ~reset & ~redirect_valid & out_ready & ~w_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fetch_pc  <= PC_RESET;
            r_inflight  <= '0;
            r_discard   <= '0;
            r_tag_wp    <= '0;
            r_tag_rp    <= '0;
            r_wp        <= '0;
            r_rp        <= '0;
            r_cnt       <= '0;
            r_adef_hold <= 1'b0;
            r_pending   <= 1'b0;
        end else begin
            if (redirect_valid)
                r_fetch_pc <= redirect_pc;
            else if (w_accept)
                r_fetch_pc <= r_fetch_pc + 32'd4;
            r_inflight  <= r_inflight + IW'(w_accept) - IW'(inst_sram_data_ok);
            r_discard   <= redirect_valid ? r_inflight - IW'(inst_sram_data_ok)
                                          : r_discard - IW'(inst_sram_data_ok & w_drop);
            r_adef_hold <= ~redirect_valid & (r_adef_hold | w_push_adef);
            r_pending   <= w_issue & ~inst_sram_addr_ok;
            if (w_accept)
                r_tag_wp <= (r_tag_wp == TW'(OUTSTANDING - 1)) ? '0 : r_tag_wp + 1'b1;
            if (inst_sram_data_ok)
                r_tag_rp <= (r_tag_rp == TW'(OUTSTANDING - 1)) ? '0 : r_tag_rp + 1'b1;
            if (redirect_valid) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push)
                    r_wp <= (r_wp == FW'(FIFO_DEPTH - 1)) ? '0 : r_wp + 1'b1;
                if (w_pop)
                    r_rp <= (r_rp == FW'(FIFO_DEPTH - 1)) ? '0 : r_rp + 1'b1;
                r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept)
            r_tag[r_tag_wp] <= r_fetch_pc;
        if (w_push) begin
            r_fpc[r_wp]   <= w_push_adef ? r_fetch_pc : w_tag_head;
            r_finst[r_wp] <= w_push_adef ? 32'h0 : inst_sram_rdata;
            r_fadef[r_wp] <= w_push_adef;
        end
    end

    assign out_valid       = ~reset & ~w_empty;
    assign out_pc          = out_valid ? r_fpc[r_rp] : 32'h0;
    assign out_inst        = out_valid ? r_finst[r_rp] : 32'h0;
    assign out_adef        = out_valid & r_fadef[r_rp];
    assign inst_sram_req   = w_issue;
    assign inst_sram_addr  = reset ? 32'h0 : r_fetch_pc;
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wdata = 32'h0;
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed tests with a queue-level reference model and an in-order bus responder.
module tb_if_fetch_queue;
    localparam logic [31:0] PC_RESET    = 32'h1c00_0000;
    localparam int          OUTSTANDING = 2;
    localparam int          FIFO_DEPTH  = 4;

    typedef struct { logic [31:0] pc; logic junk; } tag_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; logic adef; } ent_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; logic adef; int cyc; } log_t;
    typedef struct { logic [31:0] addr; int rem; } bus_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        fetch_stall = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_adef;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [3:0]  inst_sram_wstrb;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata = 32'h0;
    logic        inst_sram_addr_ok = 1'b0;
    logic        inst_sram_data_ok = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int lat = 1;

    tag_t        m_tags[$];
    ent_t        m_out[$];
    bus_t        bus_q[$];
    log_t        log_q[$];
    logic [31:0] acc_q[$];
    logic [31:0] m_pc;
    logic        m_hold;
    logic        m_pending;
    logic        nxt_dok;
    logic [31:0] nxt_rdata;

    if_fetch_queue #(.PC_RESET(PC_RESET), .OUTSTANDING(OUTSTANDING), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .reset(reset), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fetch_stall(fetch_stall), .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_inst(out_inst), .out_adef(out_adef), .inst_sram_req(inst_sram_req),
        .inst_sram_wr(inst_sram_wr), .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_size(inst_sram_size),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_rdata(inst_sram_rdata), .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h5a5a_5a5a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_valid = 1'b0;
        fetch_stall = 1'b0;
        step(2);
        reset = 1'b0;
        log_q.delete();
        acc_q.delete();
    endtask

    // Reference model and bus responder; both advance once per cycle from the settled inputs.
    always @(negedge clk) begin
        int   live;
        logic req_exp;
        logic adef_ok;
        tag_t t;
        if (reset) begin
            chk("rst_flags", {29'b0, out_valid, out_adef, inst_sram_req}, 32'h0);
            chk("rst_out_pc", out_pc, 32'h0);
            chk("rst_out_inst", out_inst, 32'h0);
            chk("rst_addr", inst_sram_addr, 32'h0);
            m_pc = PC_RESET;
            m_hold = 1'b0;
            m_pending = 1'b0;
            m_tags.delete();
            m_out.delete();
            bus_q.delete();
            cyc = 0;
        end else begin
            live = 0;
            for (int i = 0; i < m_tags.size(); i++) live += m_tags[i].junk ? 0 : 1;
            req_exp = !redirect_valid && (m_pending || (!fetch_stall && !m_hold && m_pc[1:0] == 2'b00 &&
                      m_tags.size() < OUTSTANDING && live + m_out.size() < FIFO_DEPTH));
            adef_ok = !redirect_valid && !m_hold && m_pc[1:0] != 2'b00 && live == 0 && m_out.size() < FIFO_DEPTH;
            chk("req", inst_sram_req, req_exp);
            if (req_exp) chk("addr", inst_sram_addr, m_pc);
            chk("ctl", {25'b0, inst_sram_wr, inst_sram_wstrb, inst_sram_size}, 32'h2);
            chk("wdata", inst_sram_wdata, 32'h0);
            chk("out_valid", out_valid, m_out.size() > 0);
            if (m_out.size() > 0) begin
                chk("out_pc", out_pc, m_out[0].pc);
                chk("out_inst", out_inst, m_out[0].inst);
                chk("out_adef", out_adef, m_out[0].adef);
            end
            if (out_valid && out_ready && !redirect_valid) log_q.push_back('{out_pc, out_inst, out_adef, cyc});
            if (inst_sram_req && inst_sram_addr_ok) acc_q.push_back(inst_sram_addr);
            if (out_ready && m_out.size() > 0) m_out.delete(0);
            if (inst_sram_data_ok) begin
                chk("tag_avail", m_tags.size() > 0, 1);
                if (m_tags.size() > 0) begin
                    t = m_tags.pop_front();
                    if (!t.junk) m_out.push_back('{t.pc, inst_sram_rdata, 1'b0});
                end
            end
            if (adef_ok) begin
                m_out.push_back('{m_pc, 32'h0, 1'b1});
                m_hold = 1'b1;
            end
            if (req_exp && inst_sram_addr_ok) begin
                m_tags.push_back('{m_pc, 1'b0});
                m_pc += 32'd4;
            end
            m_pending = req_exp && !inst_sram_addr_ok;
            if (redirect_valid) begin
                for (int i = 0; i < m_tags.size(); i++) m_tags[i].junk = 1'b1;
                m_out.delete();
                m_pc = redirect_pc;
                m_hold = 1'b0;
            end
            if (inst_sram_data_ok && bus_q.size() > 0) bus_q.delete(0);
            if (inst_sram_req && inst_sram_addr_ok) bus_q.push_back('{inst_sram_addr, lat});
            for (int i = 0; i < bus_q.size(); i++) bus_q[i].rem--;
            cyc++;
        end
        nxt_dok = bus_q.size() > 0 && bus_q[0].rem <= 0;
        nxt_rdata = nxt_dok ? inst_of(bus_q[0].addr) : 32'h0;
    end

    always @(posedge clk) begin
        #1;
        inst_sram_data_ok = nxt_dok;
        inst_sram_rdata = nxt_rdata;
    end

    always @(negedge clk) begin
        if (!reset) begin
            assert (!(dut.w_push && dut.w_full)) else begin
                n_err++;
                $display("FAIL fifo_overflow: push into a full queue, got push=1 expected none");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // straight line, zero-wait bus
        lat = 1;
        inst_sram_addr_ok = 1'b1;
        out_ready = 1'b1;
        do_reset();
        step(12);
        chk("t1_count", log_q.size() >= 3, 1);
        if (log_q.size() >= 3) begin
            chk("t1_pc0", log_q[0].pc, 32'h1c00_0000);
            chk("t1_inst0", log_q[0].inst, 32'h465a_5a5a);
            chk("t1_cyc0", log_q[0].cyc, 2);
            chk("t1_pc1", log_q[1].pc, 32'h1c00_0004);
            chk("t1_cyc1", log_q[1].cyc, 3);
            chk("t1_pc2", log_q[2].pc, 32'h1c00_0008);
            chk("t1_cyc2", log_q[2].cyc, 4);
        end
        // backpressure fills the queue after exactly FIFO_DEPTH accepts
        out_ready = 1'b0;
        do_reset();
        step(10);
        chk("t2_accepts", acc_q.size(), 4);
        chk("t2_no_pop", log_q.size(), 0);
        out_ready = 1'b1;
        log_q.delete();
        acc_q.delete();
        step(8);
        chk("t2_count", log_q.size() >= 5, 1);
        if (log_q.size() >= 5)
            for (int i = 0; i < 5; i++) chk("t2_pc", log_q[i].pc, PC_RESET + 32'(4 * i));
        chk("t2_resume", acc_q.size() > 0 ? acc_q[0] : 32'h0, 32'h1c00_0010);
        // redirect with two requests in flight
        lat = 3;
        do_reset();
        step(2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h1c00_0100;
        log_q.delete();
        step();
        redirect_valid = 1'b0;
        step(10);
        chk("t3_count", log_q.size() >= 1, 1);
        if (log_q.size() >= 1) chk("t3_pc", log_q[0].pc, 32'h1c00_0100);
        // redirect coinciding with a data_ok
        lat = 2;
        do_reset();
        step(2);
        redirect_valid = 1'b1;
        redirect_pc = 32'h1c00_0200;
        log_q.delete();
        step();
        redirect_valid = 1'b0;
        step(8);
        chk("t4_count", log_q.size() >= 1, 1);
        if (log_q.size() >= 1) begin
            chk("t4_pc", log_q[0].pc, 32'h1c00_0200);
            chk("t4_inst", log_q[0].inst, 32'h465a_585a);
        end
        // misaligned target raises ADEF and halts fetch until the next redirect
        redirect_valid = 1'b1;
        redirect_pc = 32'h1c00_0102;
        log_q.delete();
        acc_q.delete();
        step();
        redirect_valid = 1'b0;
        step(10);
        chk("t5_count", log_q.size(), 1);
        if (log_q.size() >= 1) begin
            chk("t5_pc", log_q[0].pc, 32'h1c00_0102);
            chk("t5_inst", log_q[0].inst, 32'h0);
            chk("t5_adef", log_q[0].adef, 1);
        end
        chk("t5_no_req", acc_q.size(), 0);
        redirect_valid = 1'b1;
        redirect_pc = 32'h1c00_0300;
        log_q.delete();
        step();
        redirect_valid = 1'b0;
        step(8);
        chk("t5_count2", log_q.size() >= 1, 1);
        if (log_q.size() >= 1) begin
            chk("t5_resume_pc", log_q[0].pc, 32'h1c00_0300);
            chk("t5_resume_adef", log_q[0].adef, 0);
        end
        // stall does not withdraw a pending request
        lat = 1;
        inst_sram_addr_ok = 1'b0;
        do_reset();
        step();
        fetch_stall = 1'b1;
        step(2);
        @(negedge clk);
        chk("t6_hold_req", inst_sram_req, 1);
        chk("t6_hold_addr", inst_sram_addr, 32'h1c00_0000);
        step();
        inst_sram_addr_ok = 1'b1;
        step();
        @(negedge clk);
        chk("t6_stalled_req", inst_sram_req, 0);
        step(2);
        @(negedge clk);
        chk("t6_still_stalled", inst_sram_req, 0);
        step();
        fetch_stall = 1'b0;
        @(negedge clk);
        chk("t6_resume_req", inst_sram_req, 1);
        chk("t6_resume_addr", inst_sram_addr, 32'h1c00_0004);
        step(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
